// File: rtl/posit_encoder_pp_if.sv
// Decoded-posit handshake channel.
//   pd_pkg::pd_type_e : flavour of decoded operand carried by the channel.
//   pd_control_if     : rts/rtr handshake plus sow/eow framing and the decoded
//                       fields (sign, scale, fraction, guard, round, sticky,
//                       zero, NaR). FRAC_W and SCALE_W are derived from the
//                       posit geometry so producers and consumers agree.
package pd_pkg;
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    ROUNDED = 2'd1,
    DIVSQRT = 2'd2
  } pd_type_e;
endpackage

interface pd_control_if #(
  parameter int                POSIT_WIDTH = 8,
  parameter int                POSIT_ES    = 0,
  parameter pd_pkg::pd_type_e  PD_TYPE     = pd_pkg::NORMAL
);
  // Widest fraction a posit can carry: N minus sign and a 2-bit regime minus ES.
  localparam int FRAC_W  = (POSIT_WIDTH - 3 - POSIT_ES > 0) ? POSIT_WIDTH - 3 - POSIT_ES : 1;
  // Wide enough to hold scales beyond +/-maxpos so the encoder can clamp them.
  localparam int SCALE_W = $clog2(POSIT_WIDTH) + POSIT_ES + 2;

  logic                      rts;
  logic                      rtr;
  logic                      sow;
  logic                      eow;
  logic                      sign;
  logic signed [SCALE_W-1:0] scale;
  logic [FRAC_W-1:0]         fraction;
  logic                      guard;
  logic                      round;
  logic                      sticky;
  logic                      zero;
  logic                      NaR;

  modport master (output rts, sow, eow, sign, scale, fraction, guard, round, sticky, zero, NaR,
                  input  rtr);
  modport slave  (input  rts, sow, eow, sign, scale, fraction, guard, round, sticky, zero, NaR,
                  output rtr);
endinterface

// File: rtl/posit_encoder_pp.sv
// Two-stage pipelined posit encoder.
//   clk, rst_n : clock, synchronous active-low reset
//   operand    : decoded posit in (pd_control_if.slave, rts/rtr handshake)
//   posit_o    : encoded posit pattern, sow_o/eow_o framing aligned with it
//   rts_o      : posit_o valid; rtr_i : downstream ready
// Stage 1 clamps the scale and lays out the unbounded body (regime, exponent,
// fraction, guard, round). Stage 2 rounds the body to N-1 bits with
// round-to-nearest-even, saturates, and applies sign / zero / NaR.
module posit_encoder_pp #(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pd_control_if.slave            operand,
  output logic [POSIT_WIDTH-1:0] posit_o,
  output logic                   sow_o,
  output logic                   eow_o,
  output logic                   rts_o,
  input  logic                   rtr_i
);
  localparam int N      = POSIT_WIDTH;
  localparam int ES     = POSIT_ES;
  localparam int FW     = (N - 3 - ES > 0) ? N - 3 - ES : 1;
  localparam int SW     = $clog2(N) + ES + 2;
  localparam int TW     = ES + FW + 2;      // exponent, fraction, guard, round
  localparam int BW     = N + TW;           // longest regime is N bits
  localparam int MAXS   = (N - 2) << ES;
  localparam int STAGES = 2;

  localparam logic signed [SW-1:0] MAXS_S = SW'(MAXS);
  localparam logic [BW-1:0]        ONES   = '1;
  localparam logic [BW-1:0]        TOP    = {1'b1, {(BW-1){1'b0}}};

  if (operand.POSIT_WIDTH != POSIT_WIDTH || operand.POSIT_ES != POSIT_ES ||
      operand.PD_TYPE != pd_pkg::NORMAL) begin : g_param_chk
    $fatal(1, "posit_encoder_pp: operand interface parameters do not match the encoder");
  end

  typedef struct packed {
    logic          sow;
    logic          eow;
    logic          sign;
    logic          zero;
    logic          nar;
    logic          sticky;
    logic          guard;
    logic          round;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
  } op_t;

  logic            process_en, rtr_q, in_fire;
  logic            skid_v, src_vld;
  op_t             skid_op, in_op, src;
  logic [STAGES:1] vld_pipe;

  assign process_en  = rtr_i | ~rts_o;
  assign operand.rtr = rtr_q;
  assign in_fire     = operand.rts & rtr_q;
  assign rts_o       = vld_pipe[STAGES];

  // A skid entry always wins: rtr is a cycle late, so while the skid drains
  // rtr_q is still 0 and no new input can arrive in the same cycle.
  always_comb begin
    in_op = '{sow: operand.sow, eow: operand.eow, sign: operand.sign,
              zero: operand.zero, nar: operand.NaR, sticky: operand.sticky,
              guard: operand.guard, round: operand.round,
              scale: operand.scale, frac: operand.fraction};
    src     = skid_v ? skid_op : in_op;
    src_vld = skid_v | in_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rtr_q   <= 1'b0;
      skid_v  <= 1'b0;
      skid_op <= '0;
    end else begin
      rtr_q <= process_en;
      if (!process_en && in_fire) begin
        skid_v  <= 1'b1;
        skid_op <= in_op;
      end else if (process_en) begin
        skid_v  <= 1'b0;
      end
    end
  end

  // ---------------- stage 1: clamp and body layout ----------------
  logic signed [SW-1:0] sc, k;
  logic [SW-1:0]        rlen;
  logic [TW-1:0]        tail;
  logic [BW-1:0]        body;

  always_comb begin
    sc = $signed(src.scale);
    if (sc > MAXS_S)       sc = MAXS_S;
    else if (sc < -MAXS_S) sc = -MAXS_S;
    k    = sc >>> ES;
    rlen = k[SW-1] ? $unsigned(-k) : $unsigned(k + SW'(1));
  end

  if (ES > 0) begin : g_tail_e
    assign tail = {sc[ES-1:0], src.frac, src.guard, src.round};
  end else begin : g_tail
    assign tail = {src.frac, src.guard, src.round};
  end

  // Regime is a run of rlen identical bits plus an opposite terminator; the
  // tail follows it. BW is sized so nothing is lost here -- truncation to
  // N-1 bits happens only in stage 2 where dropped bits feed R and S.
  always_comb begin
    if (!k[SW-1]) body = ~(ONES >> rlen);
    else          body = TOP >> rlen;
    body = body | ({tail, {N{1'b0}}} >> (rlen + SW'(1)));
  end

  logic          s1_sow, s1_eow, s1_sign, s1_zero, s1_nar, s1_sticky;
  logic [BW-1:0] s1_body;

  // ---------------- stage 2: round, saturate, sign ----------------
  logic [N-2:0] b, b_rnd;
  logic         r_bit, s_bit;
  logic [N-1:0] mag, p_nxt;

  always_comb begin
    b     = s1_body[BW-1 -: N-1];
    r_bit = s1_body[BW-N];
    s_bit = (|s1_body[BW-N-1:0]) | s1_sticky;
    b_rnd = b;
    // Never carry out of an all-ones body: that would wrap into NaR / zero.
    if (r_bit && (b[0] || s_bit) && !(&b)) b_rnd = b + 1'b1;
    if (b_rnd == '0) b_rnd = {{(N-2){1'b0}}, 1'b1};
    mag = {1'b0, b_rnd};
    if (s1_nar)       p_nxt = {1'b1, {(N-1){1'b0}}};
    else if (s1_zero) p_nxt = '0;
    else if (s1_sign) p_nxt = -mag;
    else              p_nxt = mag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_sow    <= 1'b0;
      s1_eow    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
      s1_sticky <= 1'b0;
      s1_body   <= '0;
      posit_o   <= '0;
      sow_o     <= 1'b0;
      eow_o     <= 1'b0;
    end else if (process_en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], src_vld};
      s1_sow    <= src.sow;
      s1_eow    <= src.eow;
      s1_sign   <= src.sign;
      s1_zero   <= src.zero;
      s1_nar    <= src.nar;
      s1_sticky <= src.sticky;
      s1_body   <= body;
      posit_o   <= p_nxt;
      sow_o     <= s1_sow;
      eow_o     <= s1_eow;
    end
  end
endmodule

// File: tb/tb_posit_encoder_pp.sv
// Bench for posit_encoder_pp (N=8, ES=0): directed spec vectors, a stalled
// stream, mid-flight reset and a randomized run with random downstream
// backpressure. Expected posits come from a nearest-value search over all
// positive posit patterns.
module tb_posit_encoder_pp;
  localparam int N  = 8;
  localparam int ES = 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rtr_i = 1'b1;
  logic [N-1:0] posit_o;
  logic         sow_o, eow_o, rts_o;

  pd_control_if #(.POSIT_WIDTH(N), .POSIT_ES(ES)) opif ();

  posit_encoder_pp #(.POSIT_WIDTH(N), .POSIT_ES(ES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .operand (opif),
    .posit_o (posit_o),
    .sow_o   (sow_o),
    .eow_o   (eow_o),
    .rts_o   (rts_o),
    .rtr_i   (rtr_i)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [N+1:0] exp_q[$];
  int           hold_lo = 0;
  bit           rand_rtr = 0;
  bit           acc;
  int           emitted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of positive posit pattern p (1..127), in units of 2^-14.
  function automatic longint pval(input int p);
    logic [6:0] b;
    int         run, k, fn;
    bit         going;
    longint     fr;
    b = 7'(p);
    run = 0;
    going = 1;
    for (int i = 6; i >= 0; i--) begin
      if (going && b[i] == b[6]) run++;
      else going = 0;
    end
    k  = b[6] ? run - 1 : -run;
    fn = (run >= 6) ? 0 : 6 - run;
    fr = longint'(b) & ((longint'(1) << fn) - 1);
    return ((longint'(1) << fn) + fr) << (k + 14 - fn);
  endfunction

  // Nearest posit to 2^scale * 1.frac g r (+sticky epsilon), ties to even pattern.
  function automatic logic [N-1:0] model(input bit sign, input bit zero, input bit nar,
                                         input int scale, input int frac,
                                         input bit g, input bit r, input bit s);
    longint v, d, best_d;
    int     best;
    if (nar)  return 8'h80;
    if (zero) return 8'h00;
    if (scale > 6)  scale = 6;
    if (scale < -6) scale = -6;
    v = longint'((128 + 4*frac + 2*int'(g) + int'(r)) * 2 + int'(s)) << (scale + 6);
    best = 1;
    best_d = -1;
    for (int p = 1; p < 128; p++) begin
      d = (v > pval(p)) ? v - pval(p) : pval(p) - v;
      if (best_d < 0 || d < best_d || (d == best_d && p % 2 == 0)) begin
        best = p;
        best_d = d;
      end
    end
    if (sign) best = 256 - best;
    return N'(best);
  endfunction

  // One clock: record input/output transfers just before the edge.
  task automatic step();
    logic [N+1:0] e;
    @(negedge clk);
    acc = opif.rts && opif.rtr;
    if (acc)
      exp_q.push_back({opif.sow, opif.eow,
                       model(opif.sign, opif.zero, opif.NaR, int'(opif.scale),
                             int'(opif.fraction), opif.guard, opif.round, opif.sticky)});
    if (rts_o && rtr_i) begin
      emitted++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_out observed=%0h expected=none", posit_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_out", {22'd0, sow_o, eow_o, posit_o}, {22'd0, e});
      end
    end
    @(posedge clk);
    #1;
    if (hold_lo > 0) begin
      rtr_i = 1'b0;
      hold_lo--;
    end else begin
      rtr_i = rand_rtr ? ($urandom_range(3) != 0) : 1'b1;
    end
  endtask

  task automatic send(input bit sow, input bit eow, input bit sign, input bit zero,
                      input bit nar, input int scale, input int frac,
                      input bit g, input bit r, input bit s);
    bit done;
    opif.rts = 1'b1;  opif.sow = sow;   opif.eow = eow;   opif.sign = sign;
    opif.zero = zero; opif.NaR = nar;   opif.scale = 5'(scale);
    opif.fraction = 5'(frac); opif.guard = g; opif.round = r; opif.sticky = s;
    done = 0;
    for (int n = 0; n < 60; n++) begin
      if (!done) begin
        step();
        done = acc;
      end
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
    opif.rts = 1'b0;
  endtask

  task automatic send_rand(input bit sow, input bit eow);
    send(sow, eow, 1'($urandom), $urandom_range(15) == 0, $urandom_range(15) == 0,
         int'($urandom_range(20)) - 10, int'($urandom_range(31)),
         1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic directed(input string tag, input bit sign, input bit zero, input bit nar,
                          input int scale, input int frac, input bit g, input bit r,
                          input bit s, input logic [7:0] want);
    send(1, 1, sign, zero, nar, scale, frac, g, r, s);
    chk({tag, "_lat"}, 32'(rts_o), 32'd0);
    step();
    chk({tag, "_rts"}, 32'(rts_o), 32'd1);
    chk(tag, 32'(posit_o), 32'(want));
    step();
  endtask

  initial begin
    opif.rts = 0; opif.sow = 0; opif.eow = 0; opif.sign = 0; opif.zero = 0;
    opif.NaR = 0; opif.scale = '0; opif.fraction = '0; opif.guard = 0;
    opif.round = 0; opif.sticky = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_posit", 32'(posit_o), 32'd0);
    chk("rst_rts",   32'(rts_o),   32'd0);
    chk("rst_sow",   32'(sow_o),   32'd0);
    chk("rst_eow",   32'(eow_o),   32'd0);
    chk("rst_rtr",   32'(opif.rtr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rtr_after_rst", 32'(opif.rtr), 32'd1);

    // directed vectors
    directed("one",        0, 0, 0,   0,  0, 0, 0, 0, 8'h40);
    directed("neg_one",    1, 0, 0,   0,  0, 0, 0, 0, 8'hC0);
    directed("two",        0, 0, 0,   1,  0, 0, 0, 0, 8'h60);
    directed("half",       0, 0, 0,  -1,  0, 0, 0, 0, 8'h20);
    directed("tie_odd",    0, 0, 0,   0,  1, 1, 0, 0, 8'h42);
    directed("tie_even",   0, 0, 0,   0,  0, 1, 0, 0, 8'h40);
    directed("zero",       0, 1, 0,   0,  0, 0, 0, 0, 8'h00);
    directed("nar",        0, 1, 1,   0,  0, 0, 0, 0, 8'h80);
    directed("maxpos",     0, 0, 0,  10,  0, 0, 0, 0, 8'h7F);
    directed("minpos",     0, 0, 0, -10,  0, 0, 0, 0, 8'h01);
    directed("neg_minpos", 1, 0, 0,  -6,  0, 0, 0, 0, 8'hFF);
    directed("regime_tie", 0, 0, 0,   5, 16, 0, 0, 0, 8'h7E);
    directed("no_nar",     0, 0, 0,   6, 31, 1, 1, 1, 8'h7F);

    // six-operand stream with a 3-cycle downstream stall
    emitted = 0;
    send_rand(1, 0);
    send_rand(0, 0);
    send_rand(0, 0);
    rtr_i = 1'b0;
    hold_lo = 2;
    send_rand(0, 0);
    chk("rtr_stall", 32'(opif.rtr), 32'd0);
    send_rand(0, 0);
    send_rand(0, 1);
    for (int n = 0; n < 20; n++) if (exp_q.size() != 0) step();
    chk("stream_count", 32'(emitted), 32'd6);

    // reset with two data in flight
    send_rand(1, 0);
    send_rand(0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rts", 32'(rts_o), 32'd0);
    chk("midrst_rtr", 32'(opif.rtr), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rtr_up", 32'(opif.rtr), 32'd1);
    emitted = 0;
    repeat (6) step();
    chk("midrst_no_out", 32'(emitted), 32'd0);

    // randomized run with random backpressure
    rand_rtr = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(4) == 0) step();
      send_rand(1'($urandom), 1'($urandom));
    end
    rand_rtr = 0;
    rtr_i = 1'b1;
    for (int n = 0; n < 40; n++) if (exp_q.size() != 0) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/posit_encoder_pp.md
POSIT_ENCODER_PP -- requirements
Module: posit_encoder_pp

Interface
REQ-001 SHALL have parameter POSIT_WIDTH, default 8, total posit width N.
REQ-002 SHALL have parameter POSIT_ES, default 0, exponent field width ES.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit, synchronous, active-low reset.
REQ-005 SHALL have port operand, pd_control_if.slave (PD_TYPE NORMAL; rts, sow, eow, sign, scale, fraction, guard, round, sticky, zero, NaR in; rtr out), decoded posit input.
REQ-006 SHALL have port posit_o, output, POSIT_WIDTH bits, encoded posit bit pattern.
REQ-007 SHALL have ports sow_o / eow_o, output, 1 bit each, start/end-of-word markers aligned with posit_o.
REQ-008 SHALL have port rts_o, output, 1 bit, posit_o valid.
REQ-009 SHALL have port rtr_i, input, 1 bit, downstream ready.
REQ-010 SHALL raise $fatal at elaboration if operand.POSIT_WIDTH/POSIT_ES differ from the module parameters or operand.PD_TYPE is not NORMAL.

Function
REQ-011 SHALL transfer a datum on any edge where rts and rtr are both 1 (input: operand.rts & operand.rtr; output: rts_o & rtr_i).
REQ-012 SHALL define process_en = rtr_i | ~rts_o; operand.rtr SHALL be process_en registered one cycle.
REQ-013 SHALL capture a datum into a one-entry skid latch when accepted while process_en = 0, and feed it to stage 1 before any new input once process_en returns to 1.
REQ-014 SHALL implement a 2-stage pipeline; latency from input transfer to rts_o = 1 is 2 cycles with no stall.
REQ-015 SHALL advance a stage only when process_en = 1; a stage with no incoming datum clears its valid bit; no datum is dropped, duplicated or reordered under any rtr_i pattern.
REQ-016 SHALL carry sow/eow unchanged alongside each datum.
REQ-017 Stage 1 SHALL clamp scale to [-MAXS, +MAXS], MAXS = (N-2)*2^ES, then split k = scale >>> ES (arithmetic), e = scale[ES-1:0].
REQ-018 Stage 1 SHALL build the unbounded body: regime = (k+1) ones then one 0 if k >= 0, else (-k) zeros then one 1; then e (ES bits); then fraction; then guard, round.
REQ-019 Stage 2 SHALL take the top N-1 body bits as B, next bit as R, OR of all remaining bits, round and incoming sticky as S, L = B[0].
REQ-020 Stage 2 SHALL round to nearest even: B + 1 when R & (L | S).
REQ-021 SHALL saturate: nonzero input never encodes to 0 (minimum body 1, minpos) and never exceeds body all-ones (maxpos); rounding never produces NaR.
REQ-022 SHALL output {0, B} if sign = 0, else two's complement of {0, B} over N bits.
REQ-023 SHALL output all-zeros when zero = 1 and NaR = 0; 1 followed by N-1 zeros when NaR = 1 (NaR takes priority over zero).
REQ-024 Fraction field truncation when the regime is long SHALL fold dropped bits into R/S per REQ-019.

Reset
REQ-025 While rst_n = 0 at a clock edge: posit_o, sow_o, eow_o, rts_o, operand.rtr, all valid bits, skid latch SHALL be 0.
REQ-026 operand.rtr SHALL become 1 on the first edge after rst_n rises (rts_o = 0 implies process_en = 1).
REQ-027 Assertion of rst_n mid-operation SHALL discard all in-flight and latched data; no output transfer of pre-reset data occurs afterwards.

Verification (N=8, ES=0, fraction 5 bits, rtr_i = 1 unless stated)
REQ-028 scale 0, fraction 0, sign 0 -> posit_o 0x40 two cycles after transfer; sign 1 -> 0xC0; scale 1 -> 0x60; scale -1 -> 0x20.
REQ-029 scale 0, fraction 5'b00001, guard 1, round 0, sticky 0 -> 0x42 (tie, odd up); fraction 0, guard 1 -> 0x40 (tie, even stays).
REQ-030 zero=1 -> 0x00; NaR=1 with zero=1 -> 0x80; scale 10 -> 0x7F; scale -10 -> 0x01; scale -6 with sign 1 -> 0xFF.
REQ-031 stream 6 operands back-to-back with rtr_i low for 3 cycles mid-stream -> all 6 posits emitted in order, sow_o on first and eow_o on last only, operand.rtr low the cycle after the stall begins.
REQ-032 assert rst_n = 0 for one cycle with 2 data in flight -> rts_o = 0 next cycle, no pre-reset posit emitted, operand.rtr = 1 the following cycle.
